// File: rtl/wb_periph_hub.sv
// wb_periph_hub: registered Wishbone fan-out from one upstream port to N_SLV peripheral slots plus a local CSR slot.
// Optional macro WB_HUB_TIMEOUT_EN adds a downstream wait timeout (DEAD_BEEF response, ERR_STATUS[1], TIMEOUT_COUNT).
//
// state | meaning
// IDLE  | waiting for an upstream strobe; CSR and unmapped accesses resolve here
// FWD   | downstream cyc/stb held on the selected slot until it acks
// RESP  | one-cycle upstream ack with read data, strobes ignored
module wb_periph_hub #(
   parameter int          N_SLV          = 4,
   parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
   parameter int          SLOT_BITS      = 16,
   parameter int          TIMEOUT_CYCLES = 255
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_i,
   input  logic                 wbs_cyc_i,
   input  logic                 wbs_stb_i,
   input  logic                 wbs_we_i,
   input  logic [3:0]           wbs_sel_i,
   input  logic [31:0]          wbs_adr_i,
   input  logic [31:0]          wbs_dat_i,
   output logic                 wbs_ack_o,
   output logic [31:0]          wbs_dat_o,
   output logic [N_SLV-1:0]     slv_cyc_o,
   output logic [N_SLV-1:0]     slv_stb_o,
   output logic                 slv_we_o,
   output logic [3:0]           slv_sel_o,
   output logic [31:0]          slv_adr_o,
   output logic [31:0]          slv_dat_o,
   input  logic [32*N_SLV-1:0]  slv_dat_i,
   input  logic [N_SLV-1:0]     slv_ack_i,
   input  logic [N_SLV-1:0]     slv_irq_i,
   output logic [N_SLV-1:0]     irq,
   output logic                 err_irq
);

   localparam int          DEC_LSB   = SLOT_BITS + 4;
   localparam logic [3:0]  CSR_SLOT  = 4'(N_SLV);
   localparam logic [31:0] ID_VAL    = {16'h4842, 8'(N_SLV), 8'h02};
   localparam logic [31:0] DEC_ERR_D = 32'hBADA_DD00;
   localparam logic [31:0] TOUT_D    = 32'hDEAD_BEEF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FWD  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t             state;
   logic [3:0]         slot_q;
   logic [N_SLV-1:0]   irq_mask;
   logic               err_dec;
   logic               err_tout;
   logic [3:0]         err_slot;
   logic [15:0]        tout_count;
   logic               tout_hit;

   logic               req;
   logic               base_hit;
   logic [3:0]         adr_slot;
   logic               is_periph;
   logic               is_csr;
   logic               dec_hit;
   logic [31:0]        adr_off;
   logic [N_SLV-1:0]   slot_onehot;
   logic               sel_ack;
   logic [31:0]        sel_dat;
   logic [31:0]        csr_rdata;
   logic               mask_wr;
   logic               err_wr;
   logic [N_SLV-1:0]   mask_be;

   assign req       = wbs_cyc_i & wbs_stb_i;
   assign base_hit  = (wbs_adr_i[31:DEC_LSB] == BASE_ADDR[31:DEC_LSB]);
   assign adr_slot  = wbs_adr_i[SLOT_BITS+3:SLOT_BITS];
   assign is_periph = base_hit && (adr_slot < CSR_SLOT);
   assign is_csr    = base_hit && (adr_slot == CSR_SLOT);
   assign adr_off   = {{(32-SLOT_BITS){1'b0}}, wbs_adr_i[SLOT_BITS-1:0]};
   assign dec_hit   = (state == ST_IDLE) && req && !is_periph && !is_csr;
   assign mask_wr   = (state == ST_IDLE) && req && is_csr && wbs_we_i && (wbs_adr_i[4:2] == 3'd1);
   assign err_wr    = (state == ST_IDLE) && req && is_csr && wbs_we_i && (wbs_adr_i[4:2] == 3'd3)
                      && wbs_sel_i[0];

   always_comb begin
      slot_onehot = '0;
      mask_be     = '0;
      for (int i = 0; i < N_SLV; i++) begin
         if (adr_slot == 4'(i))
            slot_onehot[i] = 1'b1;
         mask_be[i] = wbs_sel_i[i/8];
      end
   end

   // Only the slot latched at accept time may complete the transfer.
   always_comb begin
      sel_ack = 1'b0;
      sel_dat = '0;
      for (int i = 0; i < N_SLV; i++) begin
         if (slot_q == 4'(i)) begin
            sel_ack = slv_ack_i[i];
            sel_dat = slv_dat_i[32*i +: 32];
         end
      end
   end

   always_comb begin
      case (wbs_adr_i[4:2])
         3'd0:    csr_rdata = ID_VAL;
         3'd1:    csr_rdata = 32'(irq_mask);
         3'd2:    csr_rdata = 32'(slv_irq_i);
         3'd3:    csr_rdata = {20'h0, err_slot, 6'h0, err_tout, err_dec};
         3'd4:    csr_rdata = {16'h0, tout_count};
         default: csr_rdata = '0;
      endcase
   end

`ifdef WB_HUB_TIMEOUT_EN
   logic [15:0] tout_left;

   // Down-counter loaded on entry to FWD; the last permitted cycle is terminal count 1.
   assign tout_hit = (state == ST_FWD) && wbs_cyc_i && !sel_ack && (tout_left == 16'd1);

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         tout_left  <= '0;
         tout_count <= '0;
      end else begin
         if ((state == ST_IDLE) && req && is_periph)
            tout_left <= 16'(TIMEOUT_CYCLES);
         else if ((state == ST_FWD) && (tout_left != 16'd0))
            tout_left <= tout_left - 16'd1;
         if (tout_hit && (tout_count != 16'hFFFF))
            tout_count <= tout_count + 16'd1;
      end
   end
`else
   assign tout_hit   = 1'b0;
   assign tout_count = 16'h0;
`endif

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state     <= ST_IDLE;
         slot_q    <= '0;
         wbs_ack_o <= 1'b0;
         wbs_dat_o <= '0;
         slv_cyc_o <= '0;
         slv_stb_o <= '0;
         slv_we_o  <= 1'b0;
         slv_sel_o <= '0;
         slv_adr_o <= '0;
         slv_dat_o <= '0;
         irq_mask  <= '0;
         err_dec   <= 1'b0;
         err_tout  <= 1'b0;
         err_slot  <= '0;
         irq       <= '0;
         err_irq   <= 1'b0;
      end else begin
         irq     <= slv_irq_i & irq_mask;
         err_irq <= err_dec | err_tout;

         // A fresh error wins over a same-cycle W1C of the same bit.
         err_dec  <= (err_dec & ~(err_wr & wbs_dat_i[0])) | dec_hit;
         err_tout <= (err_tout & ~(err_wr & wbs_dat_i[1])) | tout_hit;
         if (dec_hit)
            err_slot <= adr_slot;
         else if (tout_hit)
            err_slot <= slot_q;

         if (mask_wr)
            irq_mask <= (irq_mask & ~mask_be) | (wbs_dat_i[N_SLV-1:0] & mask_be);

         case (state)
            ST_IDLE: begin
               wbs_ack_o <= 1'b0;
               wbs_dat_o <= '0;
               if (req) begin
                  slot_q    <= adr_slot;
                  slv_we_o  <= wbs_we_i;
                  slv_sel_o <= wbs_sel_i;
                  slv_adr_o <= adr_off;
                  slv_dat_o <= wbs_dat_i;
                  if (is_periph) begin
                     slv_cyc_o <= slot_onehot;
                     slv_stb_o <= slot_onehot;
                     state     <= ST_FWD;
                  end else if (is_csr) begin
                     wbs_ack_o <= 1'b1;
                     wbs_dat_o <= csr_rdata;
                     state     <= ST_RESP;
                  end else begin
                     wbs_ack_o <= 1'b1;
                     wbs_dat_o <= DEC_ERR_D;
                     state     <= ST_RESP;
                  end
               end
            end
            ST_FWD: begin
               if (!wbs_cyc_i) begin
                  slv_cyc_o <= '0;
                  slv_stb_o <= '0;
                  state     <= ST_IDLE;
               end else if (sel_ack) begin
                  slv_cyc_o <= '0;
                  slv_stb_o <= '0;
                  wbs_ack_o <= 1'b1;
                  wbs_dat_o <= sel_dat;
                  state     <= ST_RESP;
               end else if (tout_hit) begin
                  slv_cyc_o <= '0;
                  slv_stb_o <= '0;
                  wbs_ack_o <= 1'b1;
                  wbs_dat_o <= TOUT_D;
                  state     <= ST_RESP;
               end
            end
            ST_RESP: begin
               wbs_ack_o <= 1'b0;
               wbs_dat_o <= '0;
               state     <= ST_IDLE;
            end
            default: begin
               wbs_ack_o <= 1'b0;
               wbs_dat_o <= '0;
               slv_cyc_o <= '0;
               slv_stb_o <= '0;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/wb_periph_hub.md
Name: wb_periph_hub

Overview:
- Parametrised successor to the single-peripheral Wishbone wrapper.
- One upstream Wishbone slave port (WB MI A) fans out to N_SLV downstream Wishbone peripheral slots through registered address decode, with one transaction outstanding at a time.
- Adds a local CSR slot for ID, IRQ masking and bus-error status, a per-transaction timeout, and an error response for unmapped addresses.
- Sits between the user-project Wishbone bus and the peripheral instances (SPI, I2C, GPIO, ...).

Parameters:
- N_SLV, 4, number of downstream slots (1..15).
- BASE_ADDR, 32'h3000_0000, hub base address; bits above the decode field must match.
- SLOT_BITS, 16, log2 of bytes per slot window.
- TIMEOUT_CYCLES, 255, downstream wait limit in cycles (1..65535); only used with the optional feature.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  synchronous, active-high reset.
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  upstream Wishbone control.
- wbs_sel_i  in  4  byte selects.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  upstream acknowledge.
- wbs_dat_o  out  32  read data.
- slv_cyc_o  out  N_SLV  per-slot cycle.
- slv_stb_o  out  N_SLV  per-slot strobe.
- slv_we_o  out  1  shared.
- slv_sel_o  out  4  shared.
- slv_adr_o  out  32  shared; offset within slot, upper bits zero.
- slv_dat_o  out  32  shared write data.
- slv_dat_i  in  32*N_SLV  read data; slot i occupies bits [32i+31:32i].
- slv_ack_i  in  N_SLV  per-slot acknowledge.
- slv_irq_i  in  N_SLV  level interrupts from the slots.
- irq  out  N_SLV  masked interrupts.
- err_irq  out  1  bus-error interrupt.

Behaviour:
- Decode:
  - Match when wbs_adr_i bits [31:SLOT_BITS+4] equal the same bits of BASE_ADDR.
  - slot = wbs_adr_i[SLOT_BITS+3:SLOT_BITS].
  - slot < N_SLV selects a peripheral; slot == N_SLV selects the CSR slot; anything else (including a base mismatch) is unmapped.
- FSM states: IDLE, FWD, RESP.
- IDLE:
  - On wbs_cyc_i & wbs_stb_i, register adr/dat/sel/we and the slot index.
  - Peripheral hit: go to FWD and assert slv_cyc_o[slot] and slv_stb_o[slot] from the next cycle.
  - CSR hit: perform the CSR access, go to RESP.
  - Unmapped: rdata = 32'hBADA_DD00, set ERR_STATUS[0], record the slot, go to RESP.
- FWD:
  - Hold the downstream strobe until slv_ack_i[slot]; then capture slv_dat_i of that slot, deassert cyc/stb the next cycle, go to RESP.
  - Acks from non-selected slots are ignored.
- RESP: wbs_ack_o = 1 for exactly one cycle with wbs_dat_o valid, then IDLE. A strobe seen in the RESP cycle is not accepted.
- Latency:
  - Upstream strobe at T0 drives the downstream strobe at T1.
  - A downstream ack at Tk produces the upstream ack at Tk+1.
  - CSR and unmapped accesses ack at T1.
- Abort: if wbs_cyc_i falls in FWD, drop downstream cyc/stb the next cycle and return to IDLE with no ack.
- wbs_dat_o = 0 whenever wbs_ack_o = 0.
- CSR map (offset bits [4:2]; reads elsewhere return 0):
  - 0x00 ID, RO = {16'h4842, N_SLV[7:0], 8'h02}.
  - 0x04 IRQ_MASK, RW, reset 0, bits [N_SLV-1:0].
  - 0x08 IRQ_RAW, RO = slv_irq_i.
  - 0x0C ERR_STATUS, W1C on bits [1:0]. Bit0 = decode error, bit1 = timeout. Bits [11:8] = slot of the last error (RO). Writes honour wbs_sel_i.
  - 0x10 TIMEOUT_COUNT, RO, 16-bit saturating count of timeouts.
- Interrupts:
  - irq registered: irq[i] <= slv_irq_i[i] & IRQ_MASK[i].
  - err_irq registered: err_irq <= |ERR_STATUS[1:0].
  - A new error in the same cycle as a W1C write to the same bit wins, so the bit stays set.
- Reset: FSM to IDLE. All outputs 0, IRQ_MASK 0, ERR_STATUS 0, TIMEOUT_COUNT 0. Reset mid-FWD drops the downstream strobe the next cycle, with no upstream ack.

Optional Feature:
- Macro: WB_HUB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to FWD and increments each FWD cycle.
  - If it reaches TIMEOUT_CYCLES without an ack: deassert downstream cyc/stb, set rdata = 32'hDEAD_BEEF, set ERR_STATUS[1] and the slot field, increment TIMEOUT_COUNT, go to RESP.
  - An ack in the same cycle as expiry takes priority, and no error is recorded.
- Undefined: no counter; FWD waits indefinitely; ERR_STATUS[1] and TIMEOUT_COUNT read as 0.

Test Plan:
- Write 32'h1234_5678 to 0x3001_0004 with slot 1 acking at T2 -> slv_stb_o = 4'b0010 at T1–T2, slv_adr_o = 0x4, upstream ack at T3.
- Read 0x3002_0000 with slot 2 returning 0xCAFE_F00D -> wbs_dat_o = 0xCAFE_F00D during the single-cycle ack.
- Read 0x3004_0000 (CSR ID, N_SLV = 4) -> 0x4842_0402, ack at T1.
- Read 0x3007_0000 -> ack at T1, data 0xBADA_DD00, ERR_STATUS = 0x0701, err_irq = 1. Then write 0x1 to 0x3004_000C -> err_irq = 0 on the following cycle.
- IRQ_MASK = 0x5, slv_irq_i = 4'b1111 -> irq = 4'b0101 one cycle later.
- With WB_HUB_TIMEOUT_EN, TIMEOUT_CYCLES = 8, slot 3 never acks -> ack with 0xDEAD_BEEF 8 cycles after the downstream strobe rises. TIMEOUT_COUNT = 1, ERR_STATUS[1] = 1. Also cover an upstream cyc drop mid-FWD -> no ack.
